trng_ctrl: RTL and testbench
============================

TRNG_CTRL -- requirements
Module: trng_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32: bits per output word, range 2..32.
REQ-002 SHALL have parameter WARMUP, default 16: oscillator settle cycles, range 1..255.
REQ-003 SHALL have parameter REP_LIMIT, default 32: repetition-health limit in raw samples, range 2..255.
REQ-004 SHALL have port clk, input, 1: sampling and system clock.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port enable_i, input, 1: level request to generate words.
REQ-007 SHALL have port trng_en, output, 1: enable to the oscillator bank.
REQ-008 SHALL have port trng_out, input, 1: registered raw bit from the oscillator bank.
REQ-009 SHALL have port data_o, output, WIDTH: debiased random word.
REQ-010 SHALL have port valid_o, output, 1: data_o holds a complete word.
REQ-011 SHALL have port ready_i, input, 1: consumer accepts data_o.
REQ-012 SHALL have port busy_o, output, 1: FSM is not in IDLE.
REQ-013 SHALL have port error_o, output, 1: sticky repetition-health failure.

Function
REQ-014 SHALL implement the states IDLE, WARMUP, COLLECT and HOLD.
REQ-015 IDLE SHALL go to WARMUP on enable_i=1, clear the warmup counter, bit counter, pair flag and shift register, and assert trng_en from the next cycle.
REQ-016 trng_en SHALL be 1 in WARMUP, COLLECT and HOLD, and 0 in IDLE.
REQ-017 WARMUP SHALL count WARMUP cycles, ignore trng_out, then go to COLLECT.
REQ-018 COLLECT SHALL sample trng_out every cycle.
REQ-019 Samples SHALL form pairs: the first sample is stored and the second completes the pair.
REQ-020 Pair (0,1) SHALL yield bit 0, pair (1,0) SHALL yield bit 1, and pairs (0,0) and (1,1) SHALL be discarded.
REQ-021 Each yielded bit SHALL shift into the LSB of the shift register, with earlier bits moving toward the MSB.
REQ-022 When the WIDTH-th bit is yielded, the next state SHALL be HOLD, data_o SHALL equal the shift register, and valid_o SHALL be 1 from the following cycle.
REQ-023 HOLD SHALL keep data_o and valid_o stable until ready_i=1.
REQ-024 HOLD SHALL NOT sample or pair trng_out.
REQ-025 A transfer SHALL occur on a cycle with valid_o=1 and ready_i=1.
REQ-026 After a transfer, valid_o SHALL be 0 next cycle, the bit counter and pair flag SHALL clear, and the FSM SHALL return to COLLECT with no re-warmup when enable_i=1.
REQ-027 After a transfer with enable_i=0, the FSM SHALL return to IDLE.
REQ-028 enable_i=0 in WARMUP or COLLECT SHALL force IDLE next cycle, drop trng_en, and discard the partial word.
REQ-029 enable_i=0 in HOLD SHALL keep the word valid until it transfers, then go to IDLE.
REQ-030 ready_i while valid_o=0 SHALL have no effect.
REQ-031 The health counter SHALL count consecutive equal raw samples in COLLECT.
REQ-032 When the health counter reaches REP_LIMIT, error_o SHALL set the next cycle and stay set.
REQ-033 error_o SHALL clear only on reset or on an IDLE-to-WARMUP transition.
REQ-034 Word generation SHALL continue while error_o=1.
REQ-035 The health counter SHALL saturate and SHALL reset on any sample differing from the previous one.
REQ-036 busy_o SHALL be 1 in every state except IDLE.
REQ-037 Minimum latency from enable_i rising to valid_o SHALL be 1+WARMUP+2*WIDTH+1 cycles.

Reset
REQ-038 rst_n=0 SHALL asynchronously force IDLE, trng_en=0, valid_o=0, data_o=0, busy_o=0, error_o=0, and clear all counters and flags.
REQ-039 Release of rst_n SHALL be synchronous to clk, with no output change before the first clk edge after release.

Verification
REQ-040 With WIDTH=8, WARMUP=4 and trng_out alternating 0,1 per cycle from COLLECT entry: valid_o rises 1+4+16+1=22 cycles after enable_i, with data_o=8'h00.
REQ-041 With WIDTH=8 and pairs (1,0)x4, (1,1)x3, (0,1)x4: data_o=8'hF0, and valid_o rises 6 cycles later than in REQ-040.
REQ-042 With valid_o=1 and ready_i low for 10 cycles: data_o is stable; when ready_i pulses, valid_o=0 next cycle and no warmup occurs before the next word.
REQ-043 With enable_i dropped after 5 collected bits: trng_en=0 and busy_o=0 next cycle; on re-enable, warmup repeats and the old bits are absent from data_o.
REQ-044 With trng_out held 1 for 32 COLLECT cycles (REP_LIMIT=32): error_o=1 and stays 1 after trng_out toggles; a disable/enable cycle clears it.
REQ-045 With rst_n asserted mid-COLLECT and mid-HOLD: all outputs are 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/trng_ctrl.sv
// trng_ctrl: sequences a ring-oscillator TRNG bank. It warms up the oscillators,
// von Neumann debiases the raw bit stream into WIDTH-bit words, hands them out
// over a valid/ready handshake and flags stuck oscillators with a
// repetition-count health test.
module trng_ctrl #(
   parameter int WIDTH     = 32,
   parameter int WARMUP    = 16,
   parameter int REP_LIMIT = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable_i,
   output logic             trng_en,
   input  logic             trng_out,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic             busy_o,
   output logic             error_o
);

   localparam int BW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_COLLECT, S_HOLD} state_t;

   state_t           state;
   state_t           state_nxt;

   logic [7:0]       warm_cnt;
   logic [BW-1:0]    bit_cnt;
   logic             pair_flag;   // first sample of a pair is held in first_bit
   logic             first_bit;
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] data_q;
   logic             prev_bit;    // previous raw sample, for the repetition test
   logic [7:0]       rep_cnt;     // 0 means no sample seen since start
   logic [7:0]       rep_nxt;
   logic             err_q;

   logic             start;
   logic             warm_done;
   logic             sample;
   logic             yield;
   logic             word_done;
   logic             xfer;
   logic [WIDTH-1:0] shift_nxt;

   // Decode this cycle's events; a disabled COLLECT cycle takes no sample
   always_comb begin
      start     = (state == S_IDLE) && enable_i;
      warm_done = (state == S_WARMUP) && (warm_cnt == 8'(WARMUP - 1));
      sample    = (state == S_COLLECT) && enable_i;
      // Unequal pair yields its first sample: (1,0) -> 1, (0,1) -> 0
      yield     = sample && pair_flag && (first_bit != trng_out);
      word_done = yield && (bit_cnt == BW'(WIDTH - 1));
      xfer      = (state == S_HOLD) && ready_i;
      shift_nxt = {shift_reg[WIDTH-2:0], first_bit};
      if ((rep_cnt != 8'd0) && (trng_out == prev_bit))
         rep_nxt = (rep_cnt == 8'(REP_LIMIT)) ? rep_cnt : rep_cnt + 8'd1;
      else
         rep_nxt = 8'd1;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic; losing enable aborts everything except a pending word
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (enable_i)
               state_nxt = S_WARMUP;
         end
         S_WARMUP: begin
            if (!enable_i)
               state_nxt = S_IDLE;
            else if (warm_done)
               state_nxt = S_COLLECT;
         end
         S_COLLECT: begin
            if (!enable_i)
               state_nxt = S_IDLE;
            else if (word_done)
               state_nxt = S_HOLD;
         end
         S_HOLD: begin
            if (ready_i)
               state_nxt = enable_i ? S_COLLECT : S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs decoded from the current state
   always_comb begin
      trng_en = (state != S_IDLE);
      busy_o  = (state != S_IDLE);
      valid_o = (state == S_HOLD);
      data_o  = data_q;
      error_o = err_q;
   end

   // Warmup timer, pairing, shift register, word latch and health counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         warm_cnt  <= 8'd0;
         bit_cnt   <= '0;
         pair_flag <= 1'b0;
         first_bit <= 1'b0;
         shift_reg <= '0;
         data_q    <= '0;
         prev_bit  <= 1'b0;
         rep_cnt   <= 8'd0;
         err_q     <= 1'b0;
      end else if (start) begin
         warm_cnt  <= 8'd0;
         bit_cnt   <= '0;
         pair_flag <= 1'b0;
         shift_reg <= '0;
         rep_cnt   <= 8'd0;
         err_q     <= 1'b0;
      end else begin
         if (state == S_WARMUP)
            warm_cnt <= warm_cnt + 8'd1;
         if (sample) begin
            pair_flag <= ~pair_flag;
            if (!pair_flag)
               first_bit <= trng_out;
            prev_bit <= trng_out;
            rep_cnt  <= rep_nxt;
            if (rep_nxt == 8'(REP_LIMIT))
               err_q <= 1'b1;
         end
         if (yield) begin
            shift_reg <= shift_nxt;
            bit_cnt   <= word_done ? '0 : bit_cnt + BW'(1);
         end
         if (word_done)
            data_q <= shift_nxt;
         // Next word starts on a fresh pair boundary
         if (xfer) begin
            bit_cnt   <= '0;
            pair_flag <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_trng_ctrl.sv
// tb_trng_ctrl: directed vectors and corner sequences for trng_ctrl, followed
// by a randomized run compared against a transaction-level reference model.
module tb_trng_ctrl;

   localparam int WIDTH     = 8;
   localparam int WARMUP    = 4;
   localparam int REP_LIMIT = 32;

   logic             clk;
   logic             rst_n;
   logic             enable_i;
   logic             trng_en;
   logic             trng_out;
   logic [WIDTH-1:0] data_o;
   logic             valid_o;
   logic             ready_i;
   logic             busy_o;
   logic             error_o;

   int total = 0;
   int bad   = 0;

   trng_ctrl #(
      .WIDTH     (WIDTH),
      .WARMUP    (WARMUP),
      .REP_LIMIT (REP_LIMIT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable_i (enable_i),
      .trng_en  (trng_en),
      .trng_out (trng_out),
      .data_o   (data_o),
      .valid_o  (valid_o),
      .ready_i  (ready_i),
      .busy_o   (busy_o),
      .error_o  (error_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   // Raw sample k is presented during the k-th COLLECT cycle; off is the number
   // of negedges from the start negedge to the first COLLECT cycle. valid_o must
   // be seen exactly off+n negedges after the start negedge.
   task automatic run_word(input logic [63:0] raw, input int n, input int off,
                           input logic [7:0] exp, input string nm);
      int lat;
      int k;
      lat = -1;
      for (int s = 1; s <= off + n + 40; s++) begin
         @(negedge clk);
         if (s == 1)
            chk({nm, " first cycle"}, {valid_o, busy_o, trng_en}, 3'b011);
         if (valid_o === 1'b1) begin
            lat = s;
            break;
         end
         k = s - off;
         trng_out = (k >= 0 && k < n) ? raw[k] : 1'($urandom);
         ready_i  = 1'($urandom);
      end
      ready_i = 1'b0;
      chk({nm, " latency"}, lat, off + n);
      chk({nm, " data"}, data_o, exp);
   endtask

   // Accept the held word with enable low; the block must go idle
   task automatic drain(input string nm);
      ready_i  = 1'b1;
      enable_i = 1'b0;
      @(negedge clk);
      ready_i = 1'b0;
      chk({nm, " idle after xfer"}, {valid_o, busy_o, trng_en}, 3'b000);
   endtask

   // Reference model: phase plus debiased bit queue and run-length counter
   int        m_mode;      // 0 idle, 1 warmup, 2 collect, 3 hold
   int        m_wleft;
   int        m_first;     // -1 when no half pair is pending
   int        m_bits[$];
   int        m_run;
   int        m_last;
   logic      m_err;
   logic [7:0] m_word;

   task automatic m_step(input logic en, input logic rdy, input logic t);
      int w;
      case (m_mode)
         0: if (en) begin
            m_mode  = 1;
            m_wleft = WARMUP;
            m_first = -1;
            m_bits.delete();
            m_run   = 0;
            m_err   = 1'b0;
         end
         1: begin
            if (!en) m_mode = 0;
            else begin
               m_wleft--;
               if (m_wleft == 0) m_mode = 2;
            end
         end
         2: begin
            if (!en) m_mode = 0;
            else begin
               if (m_run > 0 && int'(t) == m_last)
                  m_run = (m_run < REP_LIMIT) ? m_run + 1 : m_run;
               else
                  m_run = 1;
               m_last = int'(t);
               if (m_run == REP_LIMIT) m_err = 1'b1;
               if (m_first < 0) m_first = int'(t);
               else begin
                  if (m_first != int'(t)) m_bits.push_back(m_first);
                  m_first = -1;
               end
               if (m_bits.size() == WIDTH) begin
                  w = 0;
                  foreach (m_bits[i]) w = w * 2 + m_bits[i];
                  m_word = 8'(w);
                  m_bits.delete();
                  m_mode = 3;
               end
            end
         end
         3: if (rdy) begin
            m_first = -1;
            m_mode  = en ? 2 : 0;
         end
         default: m_mode = 0;
      endcase
   endtask

   typedef struct {
      logic [63:0] raw;
      int          n;
      logic [7:0]  exp;
      string       name;
   } vec_t;

   vec_t vecs[5];
   logic stable;
   logic cur;
   logic longrun;
   logic en;
   logic rdy;
   logic t;

   initial begin
      // Raw streams, sample k in bit k
      vecs[0] = '{64'h0000_AAAA,   16, 8'h00, "alt01"};
      vecs[1] = '{64'h0000_5555,   16, 8'hFF, "pairs10"};
      vecs[2] = '{64'h002A_BF55,   22, 8'hF0, "discard11"};
      vecs[3] = '{64'h0000_9999,   16, 8'hAA, "mixed"};
      vecs[4] = '{64'h0000_6AAA,   16, 8'h01, "lsb_last"};

      rst_n    = 1'b0;
      enable_i = 1'b0;
      ready_i  = 1'b0;
      trng_out = 1'b0;
      @(negedge clk);
      chk("reset state", {trng_en, busy_o, valid_o, error_o, data_o}, 12'h000);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle after release", {trng_en, busy_o, valid_o, error_o, data_o}, 12'h000);

      // Directed words from idle; alt01 is valid in cycle 22 counting the
      // enable cycle as 1, discard11 six cycles later
      for (int v = 0; v < 5; v++) begin
         @(negedge clk);
         enable_i = 1'b1;
         run_word(vecs[v].raw, vecs[v].n, WARMUP + 1, vecs[v].exp, vecs[v].name);
         drain(vecs[v].name);
      end

      // Held word stays put while ready is low and trng_out wiggles
      @(negedge clk);
      enable_i = 1'b1;
      run_word(64'h5555, 16, WARMUP + 1, 8'hFF, "hold_word");
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         trng_out = 1'($urandom);
         if (!(valid_o === 1'b1 && data_o === 8'hFF)) stable = 1'b0;
      end
      chk("hold stable", stable, 1'b1);
      ready_i = 1'b1;
      run_word(64'h9999, 16, 1, 8'hAA, "xfer_nowarm");
      drain("xfer_nowarm");

      // Disable after five collected bits, then re-enable
      @(negedge clk);
      enable_i = 1'b1;
      for (int s = 1; s <= WARMUP + 10; s++) begin
         @(negedge clk);
         trng_out = (s > WARMUP) ? 1'(((s - WARMUP - 1) % 2) == 0) : 1'($urandom);
      end
      @(negedge clk);
      enable_i = 1'b0;
      @(negedge clk);
      chk("disable idle", {trng_en, busy_o, valid_o}, 3'b000);
      enable_i = 1'b1;
      run_word(64'hAAAA, 16, WARMUP + 1, 8'h00, "reenable");
      drain("reenable");

      // Repetition health: 31 equal samples pass, the 32nd trips error_o
      @(negedge clk);
      enable_i = 1'b1;
      for (int s = 1; s <= WARMUP + 31; s++) begin
         @(negedge clk);
         trng_out = (s > WARMUP) ? 1'b1 : 1'($urandom);
      end
      @(negedge clk);
      chk("health 31 equal", error_o, 1'b0);
      trng_out = 1'b1;
      @(negedge clk);
      chk("health 32 equal", error_o, 1'b1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         trng_out = ~trng_out;
      end
      @(negedge clk);
      chk("health sticky", {error_o, busy_o}, 2'b11);
      enable_i = 1'b0;
      @(negedge clk);
      chk("health kept in idle", {error_o, busy_o}, 2'b10);
      enable_i = 1'b1;
      @(negedge clk);
      chk("health cleared on start", {error_o, busy_o}, 2'b01);
      enable_i = 1'b0;
      @(negedge clk);

      // Asynchronous reset in COLLECT
      enable_i = 1'b1;
      for (int i = 0; i < WARMUP + 5; i++) begin
         @(negedge clk);
         trng_out = 1'($urandom);
      end
      #2;
      rst_n    = 1'b0;
      enable_i = 1'b0;
      #1;
      chk("async rst collect", {trng_en, busy_o, valid_o, error_o, data_o}, 12'h000);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("release collect", {trng_en, busy_o, valid_o, error_o, data_o}, 12'h000);

      // Asynchronous reset in HOLD
      @(negedge clk);
      enable_i = 1'b1;
      run_word(64'h5555, 16, WARMUP + 1, 8'hFF, "pre_rst_hold");
      #2;
      rst_n    = 1'b0;
      enable_i = 1'b0;
      #1;
      chk("async rst hold", {trng_en, busy_o, valid_o, error_o, data_o}, 12'h000);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("release hold", {trng_en, busy_o, valid_o, error_o, data_o}, 12'h000);

      // Randomized run against the reference model
      m_mode  = 0;
      m_wleft = 0;
      m_first = -1;
      m_bits.delete();
      m_run   = 0;
      m_last  = 0;
      m_err   = 1'b0;
      m_word  = 8'h00;
      cur     = 1'b0;
      longrun = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         chk("rand ctl", {trng_en, busy_o, valid_o, error_o},
             {m_mode != 0, m_mode != 0, m_mode == 3, m_err});
         if (m_mode == 3) chk("rand data", data_o, m_word);
         if (c % 250 == 0) longrun = ~longrun;
         en  = ($urandom_range(0, 99) < 97);
         rdy = 1'($urandom);
         if (longrun)
            t = ($urandom_range(0, 99) < 2) ? ~cur : cur;
         else
            t = 1'($urandom);
         cur      = t;
         enable_i = en;
         ready_i  = rdy;
         trng_out = t;
         m_step(en, rdy, t);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
